// File: rtl/regfile_sb.sv
// Parametrised integer register file: NRD combinational read ports, one write port with
// optional same-cycle forwarding, and a per-register busy scoreboard for pending writes.
module regfile_sb #(
    parameter int XLEN   = 32,
    parameter int NREGS  = 32,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRD*AW-1:0]   ra,
    output logic [NRD*XLEN-1:0] rd,
    output logic [NRD-1:0]      rbusy,
    input  logic                we,
    input  logic [AW-1:0]       wa,
    input  logic [XLEN-1:0]     wd,
    input  logic                iss_valid,
    input  logic [AW-1:0]       iss_rd,
    input  logic                flush
);

    logic [XLEN-1:0]  rf [NREGS];
    logic [NREGS-1:0] busy;
    logic [NREGS-1:0] busy_nxt;
    logic             wr_ok;
    logic             iss_ok;

    // x0 is never a legal target for either the write port or the issuer.
    assign wr_ok  = we && (wa != '0);
    assign iss_ok = iss_valid && (iss_rd != '0);

    // Entry 0 is cleared by reset and never written, so it stays hardwired zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                rf[i] <= '0;
            end
        end else if (wr_ok) begin
            rf[wa] <= wd;
        end
    end

    // Flush first, then the write retires its producer, then a new issue claims the
    // register; a same-cycle issue and write therefore leave the register busy.
    always_comb begin
        busy_nxt = flush ? '0 : busy;
        if (wr_ok) begin
            busy_nxt[wa] = 1'b0;
        end
        if (iss_ok) begin
            busy_nxt[iss_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    for (genvar p = 0; p < NRD; p++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
        logic            bsy;

        assign addr = ra[p*AW +: AW];

        // Forwarding ignores same-cycle issue: rbusy shows state from before this edge.
        always_comb begin
            data = rf[addr];
            bsy  = busy[addr];
            if (addr == '0) begin
                data = '0;
                bsy  = 1'b0;
            end else if ((BYPASS != 0) && we && (wa == addr)) begin
                data = wd;
                bsy  = 1'b0;
            end
        end

        assign rd[p*XLEN +: XLEN] = data;
        assign rbusy[p]           = bsy;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: a forwarding and a non-forwarding instance share stimulus.
module tb_regfile_sb;

    localparam int XLEN = 32;
    localparam int AW   = 5;

    logic            clk = 1'b0;
    logic            rst;
    logic [2*AW-1:0] ra;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic            iss_valid;
    logic [AW-1:0]   iss_rd;
    logic            flush;

    logic [2*XLEN-1:0] rd_b, rd_n;
    logic [1:0]        rbusy_b, rbusy_n;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_sb #(.XLEN(XLEN), .NREGS(32), .NRD(2), .BYPASS(1)) u_bp (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
        .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush)
    );

    regfile_sb #(.XLEN(XLEN), .NREGS(32), .NRD(2), .BYPASS(0)) u_nb (
        .clk(clk), .rst(rst), .ra(ra), .rd(rd_n), .rbusy(rbusy_n),
        .we(we), .wa(wa), .wd(wd), .iss_valid(iss_valid), .iss_rd(iss_rd), .flush(flush)
    );

    task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // inst: 1 = forwarding instance, 0 = non-forwarding instance
    task automatic chk_port(input string tag, input bit inst, input int port,
                            input logic [XLEN-1:0] exp_rd, input logic exp_busy);
        logic [XLEN-1:0] d;
        logic            b;
        d = inst ? rd_b[port*XLEN +: XLEN] : rd_n[port*XLEN +: XLEN];
        b = inst ? rbusy_b[port] : rbusy_n[port];
        chk($sformatf("%s.%s.p%0d.rd", tag, inst ? "bp" : "nb", port), d, exp_rd);
        chk($sformatf("%s.%s.p%0d.busy", tag, inst ? "bp" : "nb", port), {31'b0, b}, {31'b0, exp_busy});
    endtask

    task automatic chk_both(input string tag, input int port,
                            input logic [XLEN-1:0] exp_rd, input logic exp_busy);
        chk_port(tag, 1'b1, port, exp_rd, exp_busy);
        chk_port(tag, 1'b0, port, exp_rd, exp_busy);
    endtask

    task automatic set_ra(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        ra = {a1, a0};
    endtask

    // Advance past the next rising edge; inputs are then driven 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we = 1'b0; iss_valid = 1'b0; flush = 1'b0;
    endtask

    task automatic write_reg(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        we = 1'b1; wa = a; wd = d;
        step();
        idle();
    endtask

    task automatic issue_reg(input logic [AW-1:0] a);
        iss_valid = 1'b1; iss_rd = a;
        step();
        idle();
    endtask

    initial begin
        rst = 1'b1; ra = '0; we = 1'b0; wa = '0; wd = '0;
        iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;

        // Reset held: every address reads zero and not busy on both ports.
        for (int a = 0; a < 32; a++) begin
            set_ra(AW'(a), AW'(31 - a));
            #1;
            chk_both($sformatf("rst_a%0d", a), 0, 32'h0, 1'b0);
            chk_both($sformatf("rst_a%0d", a), 1, 32'h0, 1'b0);
        end

        @(negedge clk);
        rst = 1'b0;
        step();

        // Write x5 then assert reset mid-cycle.
        set_ra(5, 5);
        write_reg(5, 32'hDEADBEEF);
        #1;
        chk_both("x5_wr", 0, 32'hDEADBEEF, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        chk_both("x5_rst", 0, 32'h0, 1'b0);
        chk_both("x5_rst", 1, 32'h0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Zero register: write and issue to x0 have no effect.
        set_ra(0, 0);
        we = 1'b1; wa = 0; wd = 32'hFFFFFFFF; iss_valid = 1'b1; iss_rd = 0;
        #2;
        chk_both("x0_same", 0, 32'h0, 1'b0);
        step();
        idle();
        #1;
        chk_both("x0_next", 0, 32'h0, 1'b0);
        chk_both("x0_next", 1, 32'h0, 1'b0);

        // Bypass: old x7 = 0x99, new write 0x1234 seen on both ports.
        write_reg(7, 32'h99);
        set_ra(7, 7);
        we = 1'b1; wa = 7; wd = 32'h1234;
        #2;
        chk_port("byp_same", 1'b1, 0, 32'h1234, 1'b0);
        chk_port("byp_same", 1'b1, 1, 32'h1234, 1'b0);
        chk_port("byp_same", 1'b0, 0, 32'h99, 1'b0);
        chk_port("byp_same", 1'b0, 1, 32'h99, 1'b0);
        step();
        idle();
        #1;
        chk_both("byp_next", 0, 32'h1234, 1'b0);
        chk_both("byp_next", 1, 32'h1234, 1'b0);

        // Scoreboard: issue x10, hold busy 3 cycles, then write 0x55.
        set_ra(10, 0);
        iss_valid = 1'b1; iss_rd = 10;
        #2;
        chk_both("sb_iss_same", 0, 32'h0, 1'b0);
        step();
        idle();
        for (int c = 0; c < 3; c++) begin
            #1;
            chk_both($sformatf("sb_hold%0d", c), 0, 32'h0, 1'b1);
            step();
        end
        we = 1'b1; wa = 10; wd = 32'h55;
        #2;
        chk_port("sb_wr_same", 1'b1, 0, 32'h55, 1'b0);
        chk_port("sb_wr_same", 1'b0, 0, 32'h0, 1'b1);
        step();
        idle();
        #1;
        chk_both("sb_wr_next", 0, 32'h55, 1'b0);

        // Simultaneous issue and write to a busy x3: new producer keeps it busy.
        set_ra(3, 3);
        issue_reg(3);
        #1;
        chk_both("sim_busy", 0, 32'h0, 1'b1);
        we = 1'b1; wa = 3; wd = 32'hA; iss_valid = 1'b1; iss_rd = 3;
        #1;
        chk_port("sim_same", 1'b1, 1, 32'hA, 1'b0);
        chk_port("sim_same", 1'b0, 1, 32'h0, 1'b1);
        step();
        idle();
        #1;
        chk_both("sim_next", 0, 32'hA, 1'b1);

        // Flush with a concurrent issue: only x9 remains busy, contents intact.
        write_reg(1, 32'h11);
        write_reg(2, 32'h22);
        write_reg(4, 32'h44);
        issue_reg(1);
        issue_reg(2);
        issue_reg(4);
        set_ra(1, 4);
        #1;
        chk_both("fl_pre", 0, 32'h11, 1'b1);
        chk_both("fl_pre", 1, 32'h44, 1'b1);
        flush = 1'b1; iss_valid = 1'b1; iss_rd = 9;
        step();
        idle();
        set_ra(1, 2);
        #1;
        chk_both("fl_x1x2", 0, 32'h11, 1'b0);
        chk_both("fl_x1x2", 1, 32'h22, 1'b0);
        set_ra(4, 9);
        #1;
        chk_both("fl_x4x9", 0, 32'h44, 1'b0);
        chk_both("fl_x4x9", 1, 32'h0, 1'b1);
        set_ra(3, 10);
        #1;
        chk_both("fl_x3x10", 0, 32'hA, 1'b0);
        chk_both("fl_x3x10", 1, 32'h55, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
